// File: rtl/sd_pkg.sv
// Shared SD card definitions: loader and write-back FSM states, block constants
// and the block-to-controller address helper.
package sd_pkg;

  localparam int unsigned SD_BLOCK_BYTES = 512;
  localparam logic [15:0] SD_ERR_NONE    = 16'h0000;

  typedef enum logic [3:0] {
    WB_IDLE, WB_SDRST, WB_INIT_WAIT, WB_BLK_START, WB_FETCH, WB_FETCH_WAIT,
    WB_SEND_H, WB_ACK_H, WB_SEND_L, WB_ACK_L, WB_BLK_END, WB_DONE, WB_ERROR
  } sdwb_state_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_SDRST, LD_INIT_WAIT, LD_BLK_START, LD_READ, LD_STORE, LD_DONE, LD_ERROR
  } sdld_state_t;

  // SDHC cards take block numbers; standard-capacity cards take byte offsets.
  function automatic logic [31:0] sd_block_addr(input logic [31:0] blk, input logic sdhc);
    if (sdhc) begin
      return blk;
    end else begin
      return {blk[22:0], 9'h000};
    end
  endfunction

endpackage

// File: rtl/sd_byte_tx.sv
// Byte side of the SdCardCtrl 4-phase write handshake: registers the controller's
// byte request and drives the data/ack pair while the FSM sits in an ACK phase.
module sd_byte_tx
  import sd_pkg::*;
(
  input  logic       clk50,
  input  logic       reset,
  input  logic       ack_en,
  input  logic [7:0] byte_in,
  input  logic       sd_hndshk_o,
  output logic       req,
  output logic       sd_hndshk_i,
  output logic [7:0] sd_data
);

  logic       req_q, req_d;
  logic       ack_q, ack_d;
  logic [7:0] data_q, data_d;

  // Next-state for the request sampler and the data/ack drivers.
  always_comb begin
    req_d  = sd_hndshk_o;
    ack_d  = ack_en;
    data_d = 8'h00;
    if (ack_en) begin
      data_d = byte_in;
    end else begin
      data_d = 8'h00;
    end
  end

  // Handshake registers.
  always_ff @(posedge clk50) begin
    if (reset) begin
      req_q  <= 1'b0;
      ack_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      req_q  <= req_d;
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  assign req         = req_q;
  assign sd_hndshk_i = ack_q;
  assign sd_data     = data_q;

endmodule

// File: rtl/sdcard_writeback.sv
// Streams a range of 16-bit RAM words, high byte first, into raw SD blocks
// through the SdCardCtrl write path.
module sdcard_writeback
  import sd_pkg::*;
#(
  parameter logic        SDHC            = 1'b1,
  parameter int unsigned WORDS_PER_BLOCK = 256,
  parameter int unsigned RAM_TIMEOUT     = 1023
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] start_block,
  input  logic [15:0] num_blocks,
  input  logic [31:0] ram_base,
  output logic        ram_re,
  output logic [31:0] ram_address,
  input  logic [15:0] ram_rdata,
  input  logic        ram_rdata_valid,
  output logic        sd_reset,
  output logic        sd_wr,
  output logic        sd_continue,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_data,
  input  logic        sd_busy,
  input  logic        sd_hndshk_o,
  output logic        sd_hndshk_i,
  input  logic [15:0] sd_error,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] blocks_written
);

  localparam logic [15:0] WPB_LAST = 16'(WORDS_PER_BLOCK - 1);
  localparam logic [15:0] TMO_LAST = 16'(RAM_TIMEOUT - 1);
  // Gives the controller time to raise busy after sd_reset before INIT_WAIT trusts it.
  localparam logic [15:0] INIT_SETTLE = 16'd4;

  sdwb_state_t state_q, state_d;
  logic [31:0] start_q, start_d, base_q, base_d, word_cnt_q, word_cnt_d;
  logic [15:0] nblk_q, nblk_d, wib_q, wib_d, bw_q, bw_d, tmo_q, tmo_d, word_q, word_d;
  logic        sd_busy_q, sd_err_q, tx_req;
  logic        ram_re_q, ram_re_d, sd_reset_q, sd_reset_d, sd_wr_q, sd_wr_d;
  logic        sd_continue_q, sd_continue_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [31:0] ram_address_q, ram_address_d, sd_addr_q, sd_addr_d;

  // FSM next-state, counters and registered-output decode.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    base_d     = base_q;
    nblk_d     = nblk_q;
    word_cnt_d = word_cnt_q;
    wib_d      = wib_q;
    bw_d       = bw_q;
    tmo_d      = tmo_q;
    word_d     = word_q;
    case (state_q)
      WB_IDLE, WB_DONE: begin
        if (go) begin
          start_d    = start_block;
          nblk_d     = num_blocks;
          base_d     = ram_base;
          word_cnt_d = 32'd0;
          wib_d      = 16'd0;
          bw_d       = 16'd0;
          state_d    = (num_blocks == 16'd0) ? WB_DONE : WB_SDRST;
        end else begin
          state_d = state_q;
        end
      end
      WB_SDRST: begin
        tmo_d   = 16'd0;
        state_d = WB_INIT_WAIT;
      end
      WB_INIT_WAIT: begin
        if (tmo_q < INIT_SETTLE) begin
          tmo_d = tmo_q + 16'd1;
        end else if (!sd_busy_q) begin
          state_d = sd_err_q ? WB_ERROR : WB_BLK_START;
        end else begin
          state_d = state_q;
        end
      end
      WB_BLK_START: begin
        if (sd_busy_q) begin
          state_d = WB_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      WB_FETCH: begin
        tmo_d   = 16'd0;
        state_d = sd_busy_q ? WB_FETCH_WAIT : WB_ERROR;
      end
      WB_FETCH_WAIT: begin
        if (!sd_busy_q) begin
          state_d = WB_ERROR;
        end else if (ram_rdata_valid) begin
          word_d  = ram_rdata;
          state_d = WB_SEND_H;
        end else if (tmo_q == TMO_LAST) begin
          state_d = WB_ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      WB_SEND_H, WB_SEND_L: begin
        if (!sd_busy_q) begin
          state_d = WB_ERROR;
        end else if (tx_req) begin
          state_d = (state_q == WB_SEND_H) ? WB_ACK_H : WB_ACK_L;
        end else begin
          state_d = state_q;
        end
      end
      WB_ACK_H: begin
        if (!tx_req) begin
          state_d = WB_SEND_L;
        end else begin
          state_d = state_q;
        end
      end
      WB_ACK_L: begin
        if (!tx_req) begin
          word_cnt_d = word_cnt_q + 32'd1;
          if (wib_q == WPB_LAST) begin
            wib_d   = 16'd0;
            state_d = WB_BLK_END;
          end else begin
            wib_d   = wib_q + 16'd1;
            state_d = WB_FETCH;
          end
        end else begin
          state_d = state_q;
        end
      end
      WB_BLK_END: begin
        if (sd_busy_q) begin
          state_d = state_q;
        end else if (sd_err_q) begin
          state_d = WB_ERROR;
        end else begin
          bw_d    = bw_q + 16'd1;
          state_d = (bw_d == nblk_q) ? WB_DONE : WB_BLK_START;
        end
      end
      WB_ERROR: state_d = WB_ERROR;
      default:  state_d = WB_ERROR;
    endcase

    // Interface strobes follow the current state one cycle late; status tracks the next state.
    ram_re_d      = (state_q == WB_FETCH);
    ram_address_d = (state_q == WB_FETCH) ? base_q + word_cnt_q : 32'h0000_0000;
    sd_reset_d    = (state_q == WB_SDRST);
    sd_wr_d       = (state_q == WB_BLK_START);
    sd_addr_d     = (state_q == WB_BLK_START) ? sd_block_addr(start_q + {16'h0000, bw_q}, SDHC)
                                              : sd_addr_q;
    sd_continue_d = (state_q == WB_BLK_START) ? (bw_q != 16'd0) : sd_continue_q;
    busy_d        = (state_d != WB_IDLE) && (state_d != WB_DONE) && (state_d != WB_ERROR);
    done_d        = (state_d == WB_DONE);
    error_d       = (state_d == WB_ERROR);
  end

  // State, counters, controller input samplers and output registers.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q       <= WB_IDLE;
      start_q       <= 32'd0;
      base_q        <= 32'd0;
      nblk_q        <= 16'd0;
      word_cnt_q    <= 32'd0;
      wib_q         <= 16'd0;
      bw_q          <= 16'd0;
      tmo_q         <= 16'd0;
      word_q        <= 16'd0;
      sd_busy_q     <= 1'b0;
      sd_err_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      ram_address_q <= 32'd0;
      sd_reset_q    <= 1'b0;
      sd_wr_q       <= 1'b0;
      sd_addr_q     <= 32'd0;
      sd_continue_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      base_q        <= base_d;
      nblk_q        <= nblk_d;
      word_cnt_q    <= word_cnt_d;
      wib_q         <= wib_d;
      bw_q          <= bw_d;
      tmo_q         <= tmo_d;
      word_q        <= word_d;
      sd_busy_q     <= sd_busy;
      sd_err_q      <= (sd_error != SD_ERR_NONE);
      ram_re_q      <= ram_re_d;
      ram_address_q <= ram_address_d;
      sd_reset_q    <= sd_reset_d;
      sd_wr_q       <= sd_wr_d;
      sd_addr_q     <= sd_addr_d;
      sd_continue_q <= sd_continue_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  sd_byte_tx u_byte_tx (
    .clk50       (clk50),
    .reset       (reset),
    .ack_en      ((state_q == WB_ACK_H) || (state_q == WB_ACK_L)),
    .byte_in     ((state_q == WB_ACK_H) ? word_q[15:8] : word_q[7:0]),
    .sd_hndshk_o (sd_hndshk_o),
    .req         (tx_req),
    .sd_hndshk_i (sd_hndshk_i),
    .sd_data     (sd_data)
  );

  assign ram_re         = ram_re_q;
  assign ram_address    = ram_address_q;
  assign sd_reset       = sd_reset_q;
  assign sd_wr          = sd_wr_q;
  assign sd_addr        = sd_addr_q;
  assign sd_continue    = sd_continue_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign blocks_written = bw_q;

endmodule
